// File: rtl/apb_slave_pkg.sv
// Shared definitions for the APB register bridge.
//   - Default APB bus widths (APB_AW / APB_DW / APB_STRBW), unless the
//     interconnect has already defined them.
//   - Bridge FSM state encoding.
//   - Address-window check helper.
//   - Timeout counter width helper.
`ifndef APB_AW
`define APB_AW 32
`endif
`ifndef APB_DW
`define APB_DW 32
`endif
`ifndef APB_STRBW
`define APB_STRBW (`APB_DW/8)
`endif

package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // True when addr lies in [base, base+span). The arguments are widened
  // to 64 bits so that base+span cannot wrap for a window at the top of
  // the address map.
  function automatic logic in_window(input logic [63:0] base,
                                     input logic [63:0] span,
                                     input logic [63:0] addr);
    return (addr >= base) && (addr < base + span);
  endfunction

  // Width of the counter that must hold values 0..cycles.
  function automatic int tmo_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  localparam int TMO_CNT_W_DEF = tmo_cnt_w(16);

endpackage

// File: rtl/s_apb_reg_bridge.sv
// APB completer bridging one APB select line onto a simple strobe/ack
// peripheral register port.
//
// Ports:
//   s_apb_pclk_i / s_apb_preset_i : clock, async active-high reset
//   s_apb_p*_i                    : APB request (paddr, psel, penable,
//                                   pwrite, pwdata, pstrb)
//   s_apb_pready_o/prdata_o/
//   s_apb_pslverr_o               : APB response (registered)
//   reg_addr_o                    : byte offset into the window
//   reg_wr_en_o / reg_rd_en_o     : one-cycle access strobes
//   reg_wdata_o / reg_wstrb_o     : write data / byte enables (0 on reads)
//   reg_rdata_i / reg_ack_i       : peripheral completion
//
// Out-of-window or misaligned accesses answer with PSLVERR after zero wait
// states and never reach the peripheral. A peripheral that stays silent for
// TIMEOUT_CYCLES WAIT cycles gets an error response instead of a bus hang.
`ifndef APB_AW
`define APB_AW 32
`endif
`ifndef APB_DW
`define APB_DW 32
`endif
`ifndef APB_STRBW
`define APB_STRBW (`APB_DW/8)
`endif

module s_apb_reg_bridge
  import apb_slave_pkg::*;
#(
  parameter int          ADDR_W         = `APB_AW,
  parameter int          DATA_W         = `APB_DW,
  parameter int          STRB_W         = `APB_STRBW,
  parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
  parameter logic [31:0] REG_SPAN       = 32'h100,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic              s_apb_pclk_i,
  input  logic              s_apb_preset_i,
  input  logic [ADDR_W-1:0] s_apb_paddr_i,
  input  logic              s_apb_psel_i,
  input  logic              s_apb_penable_i,
  input  logic              s_apb_pwrite_i,
  input  logic [DATA_W-1:0] s_apb_pwdata_i,
  input  logic [STRB_W-1:0] s_apb_pstrb_i,
  output logic              s_apb_pready_o,
  output logic [DATA_W-1:0] s_apb_prdata_o,
  output logic              s_apb_pslverr_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic              reg_wr_en_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic [STRB_W-1:0] reg_wstrb_o,
  output logic              reg_rd_en_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  input  logic              reg_ack_i
);

  localparam int               CNT_W  = tmo_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;

  logic                setup;
  logic                bad_addr;
  logic [CNT_W-1:0]    cnt_inc;

  assign setup    = s_apb_psel_i && !s_apb_penable_i;
  assign bad_addr = !in_window(64'(BASE_ADDR), 64'(REG_SPAN), 64'(s_apb_paddr_i))
                    || (s_apb_paddr_i[1:0] != 2'b00);
  assign cnt_inc  = cnt_q + 1'b1;

  always_ff @(posedge s_apb_pclk_i or posedge s_apb_preset_i) begin
    if (s_apb_preset_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Response and strobe outputs default to 0 every cycle, so each is a
  // single-cycle pulse unless a branch below raises it.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    unique case (state_q)
      IDLE: begin
        // penable without a preceding setup is not a setup; ignore it.
        if (setup) begin
          addr_d  = s_apb_paddr_i - BASE_A;
          write_d = s_apb_pwrite_i;
          wdata_d = s_apb_pwdata_i;
          strb_d  = s_apb_pwrite_i ? s_apb_pstrb_i : '0;
          cnt_d   = '0;
          if (bad_addr) begin
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else begin
            state_d = WAIT;
            wr_en_d = s_apb_pwrite_i;
            rd_en_d = !s_apb_pwrite_i;
          end
        end
      end
      WAIT: begin
        if (!s_apb_psel_i) begin
          // Master abandoned the transfer: drop everything, any late ack
          // arrives in IDLE and is ignored there.
          state_d = IDLE;
          addr_d  = '0;
          write_d = 1'b0;
          wdata_d = '0;
          strb_d  = '0;
          cnt_d   = '0;
        end else if (reg_ack_i) begin
          // Ack beats a simultaneous timeout.
          state_d  = RESP;
          pready_d = 1'b1;
          prdata_d = write_q ? '0 : reg_rdata_i;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO) begin
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign s_apb_pready_o  = pready_q;
  assign s_apb_pslverr_o = pslverr_q;
  assign s_apb_prdata_o  = prdata_q;
  assign reg_addr_o      = addr_q;
  assign reg_wdata_o     = wdata_q;
  assign reg_wstrb_o     = strb_q;
  assign reg_wr_en_o     = wr_en_q;
  assign reg_rd_en_o     = rd_en_q;

endmodule

// File: tb/tb_s_apb_reg_bridge.sv
// Directed, table-driven bench for s_apb_reg_bridge (32-bit APB, window
// 0x4000_0000 + 0x100, timeout 16), plus hand sequences for reset and
// psel-abort during WAIT and a back-to-back pair.
module tb_s_apb_reg_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic [31:0] reg_addr, reg_wdata, reg_rdata;
  logic        reg_wr_en, reg_rd_en, reg_ack;
  logic [3:0]  reg_wstrb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  s_apb_reg_bridge #(
    .ADDR_W(32), .DATA_W(32), .STRB_W(4),
    .BASE_ADDR(32'h4000_0000), .REG_SPAN(32'h100), .TIMEOUT_CYCLES(16)
  ) dut (
    .s_apb_pclk_i(clk), .s_apb_preset_i(rst),
    .s_apb_paddr_i(paddr), .s_apb_psel_i(psel), .s_apb_penable_i(penable),
    .s_apb_pwrite_i(pwrite), .s_apb_pwdata_i(pwdata), .s_apb_pstrb_i(pstrb),
    .s_apb_pready_o(pready), .s_apb_prdata_o(prdata), .s_apb_pslverr_o(pslverr),
    .reg_addr_o(reg_addr), .reg_wr_en_o(reg_wr_en), .reg_wdata_o(reg_wdata),
    .reg_wstrb_o(reg_wstrb), .reg_rd_en_o(reg_rd_en),
    .reg_rdata_i(reg_rdata), .reg_ack_i(reg_ack)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          ack_dly;   // cycles after the strobe cycle; -1 = never
    logic [31:0] rdata;
    int          exp_lat;   // cycles from setup to PREADY
    logic        exp_err;
    logic [31:0] exp_prdata;
    int          exp_wr;    // expected write strobe pulses
    int          exp_rd;    // expected read strobe pulses
    logic [31:0] exp_off;
    logic [3:0]  exp_wstrb;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic go_idle();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    reg_ack = 1'b0; reg_rdata = '0;
  endtask

  // Called just after a clock edge. Drives setup, then access, plays the
  // peripheral, and returns one edge after PREADY with the bus still in
  // access phase so a caller may start the next setup immediately.
  task automatic run_xfer(input vec_t v, input string tag);
    int  wr_n = 0;
    int  rd_n = 0;
    int  lat  = 0;
    bit  done = 0;
    psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr;
    pwdata = v.wdata; pstrb = v.strb; reg_ack = 1'b0; reg_rdata = '0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk); #1;
      if (reg_wr_en || reg_rd_en) begin
        wr_n += int'(reg_wr_en);
        rd_n += int'(reg_rd_en);
        chk({tag, " reg_addr"}, 64'(reg_addr), 64'(v.exp_off));
        chk({tag, " reg_wstrb"}, 64'(reg_wstrb), 64'(v.exp_wstrb));
        if (reg_wr_en) chk({tag, " reg_wdata"}, 64'(reg_wdata), 64'(v.wdata));
      end
      if (pready) begin
        lat  = c;
        done = 1;
        chk({tag, " pslverr"}, 64'(pslverr), 64'(v.exp_err));
        chk({tag, " prdata"}, 64'(prdata), 64'(v.exp_prdata));
        reg_ack = 1'b0;
      end else begin
        reg_ack = (v.ack_dly >= 0) && (c == 1 + v.ack_dly);
      end
      penable   = 1'b1;
      reg_rdata = v.rdata;
    end
    chk({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
    reg_ack = 1'b0;
    @(posedge clk); #1;
    wr_n += int'(reg_wr_en);
    rd_n += int'(reg_rd_en);
    chk({tag, " pready drop"}, 64'(pready), 64'd0);
    chk({tag, " pslverr drop"}, 64'(pslverr), 64'd0);
    chk({tag, " wr pulses"}, 64'(wr_n), 64'(v.exp_wr));
    chk({tag, " rd pulses"}, 64'(rd_n), 64'(v.exp_rd));
  endtask

  task automatic idle_cycles(input int n);
    go_idle();
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ack held high while idle must not produce any response.
  task automatic late_ack(input string tag);
    reg_ack = 1'b1; reg_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk({tag, " late ack pready"}, 64'(pready), 64'd0);
    end
    reg_ack = 1'b0;
  endtask

  vec_t vt[8];
  vec_t w_b2b, r_b2b;

  initial begin
    //       wr  addr          wdata         strb dly rdata         lat err prdata        wr rd off     wstrb
    vt[0] = '{1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF,  0, 32'hFFFF_FFFF, 2, 1'b0, 32'h0,         1, 0, 32'h10, 4'hF};
    vt[1] = '{1'b0, 32'h4000_0004, 32'h0,         4'hF,  3, 32'h1234_5678, 5, 1'b0, 32'h1234_5678, 0, 1, 32'h04, 4'h0};
    vt[2] = '{1'b0, 32'h4000_0100, 32'h0,         4'h0,  0, 32'h1111_1111, 1, 1'b1, 32'h0,         0, 0, 32'h0,  4'h0};
    vt[3] = '{1'b0, 32'h4000_0002, 32'h0,         4'h0,  0, 32'h1111_1111, 1, 1'b1, 32'h0,         0, 0, 32'h0,  4'h0};
    vt[4] = '{1'b0, 32'h4000_0020, 32'h0,         4'h0, -1, 32'h2222_2222, 17, 1'b1, 32'h0,        0, 1, 32'h20, 4'h0};
    vt[5] = '{1'b0, 32'h4000_0020, 32'h0,         4'h0, 15, 32'hA5A5_5A5A, 17, 1'b0, 32'hA5A5_5A5A, 0, 1, 32'h20, 4'h0};
    vt[6] = '{1'b1, 32'h4000_00FC, 32'hCAFE_F00D, 4'h0,  1, 32'h0,         3, 1'b0, 32'h0,         1, 0, 32'hFC, 4'h0};
    vt[7] = '{1'b0, 32'h3FFF_FFFC, 32'h0,         4'h0,  0, 32'h0,         1, 1'b1, 32'h0,         0, 0, 32'h0,  4'h0};
    w_b2b = '{1'b1, 32'h4000_0040, 32'h0BAD_CAFE, 4'h3,  0, 32'h0,         2, 1'b0, 32'h0,         1, 0, 32'h40, 4'h3};
    r_b2b = '{1'b0, 32'h4000_0044, 32'h0,         4'hF,  1, 32'h7654_3210, 3, 1'b0, 32'h7654_3210, 0, 1, 32'h44, 4'h0};

    go_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset pready", 64'(pready), 64'd0);
    chk("reset pslverr", 64'(pslverr), 64'd0);
    chk("reset prdata", 64'(prdata), 64'd0);
    chk("reset reg_addr", 64'(reg_addr), 64'd0);
    chk("reset strobes", 64'({reg_wr_en, reg_rd_en}), 64'd0);
    chk("reset wdata/wstrb", 64'({reg_wdata, reg_wstrb}), 64'd0);
    rst = 1'b0;
    idle_cycles(2);

    for (int i = 0; i < 8; i++) begin
      run_xfer(vt[i], $sformatf("vec%0d", i));
      idle_cycles(1);
    end

    // penable without setup while idle is ignored
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h4000_0010; pstrb = 4'hF;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("stray penable strobe", 64'({reg_wr_en, reg_rd_en}), 64'd0);
      chk("stray penable pready", 64'(pready), 64'd0);
    end
    idle_cycles(1);

    // back-to-back: read setup in the cycle after the write's PREADY
    run_xfer(w_b2b, "b2b wr");
    run_xfer(r_b2b, "b2b rd");
    idle_cycles(1);

    // reset asserted during WAIT
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h4000_0008;
    @(posedge clk); #1;
    chk("rst-in-wait strobe", 64'(reg_rd_en), 64'd1);
    penable = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst-in-wait rd_en", 64'(reg_rd_en), 64'd0);
    chk("rst-in-wait reg_addr", 64'(reg_addr), 64'd0);
    chk("rst-in-wait pready", 64'(pready), 64'd0);
    @(posedge clk); #1;
    go_idle();
    rst = 1'b0;
    late_ack("rst-in-wait");
    run_xfer(vt[0], "after rst");
    idle_cycles(1);

    // psel dropped during WAIT
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h4000_0008;
    @(posedge clk); #1;
    chk("abort strobe", 64'(reg_rd_en), 64'd1);
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    chk("abort reg_addr", 64'(reg_addr), 64'd0);
    chk("abort strobes", 64'({reg_wr_en, reg_rd_en}), 64'd0);
    chk("abort pready", 64'(pready), 64'd0);
    late_ack("abort");
    run_xfer(vt[1], "after abort");
    idle_cycles(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
